// File: rtl/lut_prod_accum_pkg.sv
// Shared multiplier package: LUT multiplier constants, accumulator defaults
// and the state encodings used by the product accumulator.
package lut_prod_accum_pkg;

  localparam int unsigned LUT_A_W   = 8;
  localparam int unsigned LUT_B_W   = 8;
  localparam int unsigned LUT_DEPTH = 1 << (LUT_A_W + LUT_B_W);

  localparam int unsigned PROD_W_DEF = LUT_A_W + LUT_B_W;
  localparam int unsigned ACC_W_DEF  = 20;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/lut_prod_accum_if.sv
// Product-beat input stream and result output stream of the accumulator.
interface lut_prod_accum_if #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_ovf
  );
endinterface

// File: rtl/lut_prod_accum_sat_adder.sv
// Unsigned saturating adder; carry_o flags that the true sum exceeded W bits.
module sat_adder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);
  logic [W:0] raw;

  assign raw     = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o = raw[W];
  assign sum_o   = raw[W] ? '1 : raw[W-1:0];
endmodule

// File: rtl/lut_prod_accum.sv
// Accumulates LUT multiplier products into per-block dot-product results
// with a one-entry output slot, saturation and term counting.
module lut_prod_accum
  import lut_prod_accum_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  lut_prod_accum_if.slave        bus
);
  acc_state_e       state_q;
  slot_state_e      slot_q;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, ocnt_q;
  logic             ovf_q, ovf_d, oovf_q;
  logic             acc_carry, cnt_carry_unused;
  logic             accept;

  assign bus.in_ready  = (slot_q == SLOT_EMPTY) || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready && !clr;
  assign bus.out_valid = (slot_q == SLOT_FULL);
  assign bus.out_sum   = sum_q;
  assign bus.out_cnt   = ocnt_q;
  assign bus.out_ovf   = oovf_q;

  sat_adder #(.W(ACC_W)) u_acc_add (
    .a_i     (acc_q),
    .b_i     (ACC_W'(bus.in_data)),
    .sum_o   (acc_d),
    .carry_o (acc_carry)
  );

  sat_adder #(.W(CNT_W)) u_cnt_add (
    .a_i     (cnt_q),
    .b_i     (CNT_W'(1)),
    .sum_o   (cnt_d),
    .carry_o (cnt_carry_unused)
  );

  assign ovf_d = ovf_q || acc_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC_IDLE;
      slot_q  <= SLOT_EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else if (clr) begin
      state_q <= ACC_IDLE;
      slot_q  <= SLOT_EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // A slot drain and a last-beat reload in the same cycle keep the slot full.
      if (slot_q == SLOT_FULL && bus.out_ready)
        slot_q <= SLOT_EMPTY;
      if (accept) begin
        if (bus.in_last) begin
          sum_q   <= acc_d;
          ocnt_q  <= cnt_d;
          oovf_q  <= ovf_d;
          slot_q  <= SLOT_FULL;
          acc_q   <= '0;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
          state_q <= ACC_IDLE;
        end else begin
          acc_q   <= acc_d;
          cnt_q   <= cnt_d;
          ovf_q   <= ovf_d;
          state_q <= ACC_RUN;
        end
      end
    end
  end
endmodule

// File: tb/tb_lut_prod_accum.sv
// Directed, table-driven check of lut_prod_accum plus multi-cycle corner sequences.
module tb_lut_prod_accum;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  lut_prod_accum_if #(.PROD_W(16), .ACC_W(20), .CNT_W(8)) bus ();

  lut_prod_accum #(.PROD_W(16), .ACC_W(20), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        ordy;
    logic        c;
    logic        e_ov;
    logic [19:0] e_sum;
    logic [7:0]  e_cnt;
    logic        e_ovf;
    logic        e_ir;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic l,
                       input logic ordy, input logic c);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    clr           = c;
  endtask

  // Drive for one clock, sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic l,
                      input logic ordy, input logic c);
    drive(v, d, l, ordy, c);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [19:0] s,
                         input logic [7:0] n, input logic o);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".out_sum"},   32'(bus.out_sum),   32'(s));
    chk({tag, ".out_cnt"},   32'(bus.out_cnt),   32'(n));
    chk({tag, ".out_ovf"},   32'(bus.out_ovf),   32'(o));
  endtask

  initial begin
    //            v  d    l  ordy clr  ov sum  cnt ovf ir
    vecs[0]  = '{1, 100, 0, 1, 0,     0, 0,   0, 0, 1};
    vecs[1]  = '{1, 200, 0, 1, 0,     0, 0,   0, 0, 1};
    vecs[2]  = '{1, 300, 1, 1, 0,     1, 600, 3, 0, 1};
    vecs[3]  = '{0, 0,   0, 1, 0,     0, 600, 3, 0, 1};
    vecs[4]  = '{1, 1,   0, 1, 0,     0, 600, 3, 0, 1};
    vecs[5]  = '{1, 2,   1, 1, 0,     1, 3,   2, 0, 1};
    vecs[6]  = '{1, 3,   1, 1, 0,     1, 3,   1, 0, 1};
    vecs[7]  = '{0, 0,   0, 1, 0,     0, 3,   1, 0, 1};
    vecs[8]  = '{1, 9,   1, 0, 0,     1, 9,   1, 0, 0};
    vecs[9]  = '{1, 50,  0, 0, 0,     1, 9,   1, 0, 0};
    vecs[10] = '{0, 0,   0, 1, 0,     0, 9,   1, 0, 1};
    vecs[11] = '{1, 5,   0, 1, 0,     0, 9,   1, 0, 1};
    vecs[12] = '{1, 6,   1, 1, 1,     0, 9,   1, 0, 1};
    vecs[13] = '{1, 4,   1, 0, 0,     1, 4,   1, 0, 0};
    vecs[14] = '{0, 0,   0, 0, 1,     0, 4,   1, 0, 1};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk_out("rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_rel.in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].ordy, vecs[i].c);
      chk_out($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_sum, vecs[i].e_cnt, vecs[i].e_ovf);
      chk($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ir));
    end

    // Saturation: 17 x 65535 overflows 20 bits, 16 x 65535 does not.
    for (int i = 0; i < 17; i++) step(1, 16'hFFFF, (i == 16), 1, 0);
    chk_out("sat17", 1, 20'd1048575, 8'd17, 1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 16'hFFFF, (i == 15), 1, 0);
    chk_out("sat16", 1, 20'd1048560, 8'd16, 0);
    step(0, 0, 0, 1, 0);
    chk("sat16.drain", 32'(bus.out_valid), 32'd0);

    // Back-pressure: slot held for 5 cycles, then drain and reload in one cycle.
    step(1, 42, 1, 0, 0);
    chk_out("bp.load", 1, 42, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 99, 0, 0, 0);
      chk($sformatf("bp.hold%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
      chk_out($sformatf("bp.hold%0d", i), 1, 42, 1, 0);
    end
    step(1, 7, 1, 1, 0);
    chk_out("bp.reload", 1, 7, 1, 0);
    step(0, 0, 0, 1, 0);

    // Partial block discarded by asynchronous reset.
    step(1, 10, 0, 1, 0);
    step(1, 20, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst.out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 5, 1, 1, 0);
    chk_out("mid_rst.res", 1, 5, 1, 0);
    step(0, 0, 0, 1, 0);

    // Same sequence flushed with clr instead.
    step(1, 10, 0, 1, 0);
    step(1, 20, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(1, 5, 1, 1, 0);
    chk_out("mid_clr.res", 1, 5, 1, 0);
    step(0, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
